// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial receive front end.
package serdes_pkg;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } aligner_state_t;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;
  localparam int SERDES_WORD_W = 10;

endpackage

// File: rtl/comma_detect.sv
// Combinational comma detector: flags the word against the comma pattern and its complement.
module comma_detect
  import serdes_pkg::*;
#(
  parameter int WORD_W = SERDES_WORD_W,
  parameter logic [WORD_W-1:0] COMMA_P = WORD_W'(K28_5_RDN)
) (
  input  logic [WORD_W-1:0] word,
  output logic              match,
  output logic              match_inv
);

  assign match     = (word == COMMA_P);
  assign match_inv = (word == ~COMMA_P);

endmodule

// File: rtl/rx_word_aligner.sv
// Serial-to-parallel receiver with comma-based word alignment and lock tracking.
// Define ALIGNER_BOTH_RD_EN to accept the comma in both running disparities.
module rx_word_aligner
  import serdes_pkg::*;
#(
  parameter int WORD_W = SERDES_WORD_W,
  parameter logic [WORD_W-1:0] COMMA_P = WORD_W'(K28_5_RDN),
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 4
) (
  input  logic              BitCLK,
  input  logic              Reset,
  input  logic              Serial,
  output logic [WORD_W-1:0] RxParallel,
  output logic              RxValid,
  output logic              RxComma,
  output logic              RxLocked
);

  localparam int MAX_CNT = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int CNT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);
  localparam logic [CW-1:0]    CMAX = {CW{1'b1}};

`ifdef ALIGNER_BOTH_RD_EN
  localparam bit BOTH_RD = 1'b1;
`else
  localparam bit BOTH_RD = 1'b0;
`endif

  logic [WORD_W-1:0] sr_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic [CW-1:0]     good;
  logic [CW-1:0]     bad;
  aligner_state_t    state;
  logic              match;
  logic              matchInv;
  logic              hit;
  logic              boundary;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  comma_detect #(
    .WORD_W (WORD_W),
    .COMMA_P(COMMA_P)
  ) uDetect (
    .word     (sr_p0),
    .match    (match),
    .match_inv(matchInv)
  );

  assign hit      = match | (BOTH_RD & matchInv);
  assign boundary = (cnt_p0 == LAST);

  // Stage p0 -> outputs: sr_p0 holds the word completed at the previous edge
  always_ff @(posedge BitCLK) begin
    if (Reset) begin
      sr_p0      <= '0;
      cnt_p0     <= '0;
      good       <= '0;
      bad        <= '0;
      state      <= HUNT;
      RxParallel <= '0;
      RxValid    <= 1'b0;
      RxComma    <= 1'b0;
      RxLocked   <= 1'b0;
    end else begin
      sr_p0   <= {Serial, sr_p0[WORD_W-1:1]};
      cnt_p0  <= boundary ? '0 : cnt_p0 + CNT_W'(1);
      RxValid <= 1'b0;
      RxComma <= 1'b0;
      case (state)
        HUNT: begin
          if (hit) begin
            cnt_p0     <= '0;
            RxParallel <= sr_p0;
            RxValid    <= 1'b1;
            RxComma    <= 1'b1;
            good       <= CW'(1);
            if (LOCK_CNT == 1) begin
              state    <= LOCKED;
              RxLocked <= 1'b1;
              bad      <= '0;
            end else begin
              state <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            RxParallel <= sr_p0;
            RxValid    <= 1'b1;
            RxComma    <= hit;
            if (hit) begin
              good <= satInc(good);
              if (int'(good) + 1 >= LOCK_CNT) begin
                state    <= LOCKED;
                RxLocked <= 1'b1;
                bad      <= '0;
              end
            end
          end else if (hit) begin
            // A comma off the current grid restarts verification on the new grid.
            cnt_p0     <= '0;
            RxParallel <= sr_p0;
            RxValid    <= 1'b1;
            RxComma    <= 1'b1;
            good       <= CW'(1);
          end
        end
        LOCKED: begin
          if (boundary) begin
            RxParallel <= sr_p0;
            RxValid    <= 1'b1;
            RxComma    <= hit;
            if (hit) bad <= '0;
          end else if (hit) begin
            bad <= satInc(bad);
            if (int'(bad) + 1 >= LOSS_CNT) begin
              state    <= HUNT;
              RxLocked <= 1'b0;
              good     <= '0;
              bad      <= '0;
            end
          end
        end
        default: begin
          state    <= HUNT;
          RxLocked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_word_aligner.sv
// Bench for rx_word_aligner: directed vector table plus randomized traffic against a bit-history model.
module tb_rx_word_aligner;
  import serdes_pkg::*;

  localparam int W = 10;
  localparam int LOCKN = 4;
  localparam int LOSSN = 4;
  localparam logic [W-1:0] C = K28_5_RDN;
  localparam logic [W-1:0] NC = K28_5_RDP;
`ifdef ALIGNER_BOTH_RD_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif

  logic BitCLK = 1'b0;
  logic Reset = 1'b1;
  logic Serial = 1'b0;
  logic [W-1:0] RxParallel;
  logic RxValid, RxComma, RxLocked;

  int checks = 0;
  int errors = 0;
  int strobeCnt = 0;

  rx_word_aligner #(
    .WORD_W(W), .COMMA_P(C), .LOCK_CNT(LOCKN), .LOSS_CNT(LOSSN)
  ) dut (
    .BitCLK(BitCLK), .Reset(Reset), .Serial(Serial),
    .RxParallel(RxParallel), .RxValid(RxValid), .RxComma(RxComma), .RxLocked(RxLocked)
  );

  always #5 BitCLK = ~BitCLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, exp);
    end
  endtask

  // Reference model: keeps the received bit history and the absolute edge at
  // which the current word grid was anchored; boundaries follow by modulo arithmetic.
  bit hist[$];
  int mEdge = 0, mMode = 0, mGood = 0, mBad = 0, mAlignEnd = 0;
  bit mInit = 0;
  logic [W-1:0] eParallel;
  logic eValid, eComma, eLocked;
  logic rS, bS;

  function automatic logic [W-1:0] lastWord();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = hist[hist.size() - W + i];
    return r;
  endfunction

  function automatic bit isCommaWord(input logic [W-1:0] w);
    return (w == C) || (BOTH && (w == NC));
  endfunction

  task automatic modelStep(input logic rst, input logic b);
    logic [W-1:0] wd;
    bit isC, bnd;
    mEdge++;
    if (rst) begin
      mInit = 1; mMode = 0; mGood = 0; mBad = 0; mAlignEnd = 0;
      hist.delete();
      for (int i = 0; i < W; i++) hist.push_back(1'b0);
      eParallel = '0; eValid = 0; eComma = 0; eLocked = 0;
      return;
    end
    if (!mInit) return;
    wd = lastWord();
    isC = isCommaWord(wd);
    bnd = (mMode != 0) && (((mEdge - 1 - mAlignEnd) % W) == 0);
    eValid = 0; eComma = 0;
    if (mMode == 0) begin
      if (isC) begin
        mAlignEnd = mEdge - 1; eParallel = wd; eValid = 1; eComma = 1; mGood = 1;
        if (LOCKN == 1) begin mMode = 2; mBad = 0; end else mMode = 1;
      end
    end else if (mMode == 1) begin
      if (bnd) begin
        eParallel = wd; eValid = 1; eComma = isC;
        if (isC) begin
          mGood++;
          if (mGood >= LOCKN) begin mMode = 2; mBad = 0; end
        end
      end else if (isC) begin
        mAlignEnd = mEdge - 1; eParallel = wd; eValid = 1; eComma = 1; mGood = 1;
      end
    end else begin
      if (bnd) begin
        eParallel = wd; eValid = 1; eComma = isC;
        if (isC) mBad = 0;
      end else if (isC) begin
        mBad++;
        if (mBad >= LOSSN) begin mMode = 0; mGood = 0; mBad = 0; end
      end
    end
    eLocked = (mMode == 2);
    hist.push_back(b);
    void'(hist.pop_front());
  endtask

  always begin
    @(posedge BitCLK);
    rS = Reset;
    bS = Serial;
    modelStep(rS, bS);
    @(negedge BitCLK);
    if (mInit)
      chk("model", {RxParallel, RxValid, RxComma, RxLocked}, {eParallel, eValid, eComma, eLocked});
  end

  task automatic sendBit(input logic b);
    Serial = b;
    @(posedge BitCLK);
    #1;
    if (RxValid) strobeCnt++;
  endtask

  task automatic sendWord(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) sendBit(w[i]);
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] expPar;
    logic         expComma;
    logic         expLocked;
  } vec_t;

  task automatic checkVec(input string name, input vec_t v);
    chk(name, {RxValid, RxParallel, RxComma, RxLocked}, {1'b1, v.expPar, v.expComma, v.expLocked});
  endtask

  task automatic sendWordChk(input logic [W-1:0] w, input bit doChk, input vec_t v, input string name);
    for (int i = 0; i < W; i++) begin
      sendBit(w[i]);
      if (i == 0 && doChk) checkVec(name, v);
    end
  endtask

  task automatic doReset(input int n);
    Reset = 1'b1;
    for (int i = 0; i < n; i++) sendBit(i[0]);
    Reset = 1'b0;
  endtask

  vec_t tbl[11];
  vec_t cv;

  initial begin
    int a;
    logic [W-1:0] rw;
    tbl[0]  = '{C,     C,     1'b1, 1'b0};
    tbl[1]  = '{C,     C,     1'b1, 1'b0};
    tbl[2]  = '{C,     C,     1'b1, 1'b0};
    tbl[3]  = '{C,     C,     1'b1, 1'b1};
    tbl[4]  = '{C,     C,     1'b1, 1'b1};
    tbl[5]  = '{10'h2AA, 10'h2AA, 1'b0, 1'b1};
    tbl[6]  = '{10'h155, 10'h155, 1'b0, 1'b1};
    tbl[7]  = '{NC,    NC,    BOTH, 1'b1};
    tbl[8]  = '{10'h000, 10'h000, 1'b0, 1'b1};
    tbl[9]  = '{10'h3FF, 10'h3FF, 1'b0, 1'b1};
    tbl[10] = '{C,     C,     1'b1, 1'b1};
    cv = '{C, C, 1'b1, 1'b1};

    // Reset with toggling input, then idle
    doReset(3);
    chk("resetOut", {RxParallel, RxValid, RxComma, RxLocked}, 0);
    strobeCnt = 0;
    repeat (20) sendBit(1'b0);
    chk("idleStrobes", strobeCnt, 0);
    chk("idleLocked", RxLocked, 0);

    // Offset acquisition and data in lock
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    for (int i = 0; i < 11; i++)
      sendWordChk(tbl[i].word, i > 0, (i > 0) ? tbl[i-1] : tbl[0], $sformatf("vec%0d", i - 1));
    sendBit(1'b0);
    checkVec("vec10", tbl[10]);

    // Three misaligned commas, then an aligned one keeps lock
    sendWord(C);
    sendBit(1'b0); sendWord(C);
    sendBit(1'b0); sendWord(C);
    chk("lockAfter3Bad", RxLocked, 1);
    repeat (7) sendBit(1'b0);
    sendWord(C);
    sendBit(1'b0);
    checkVec("alignedClearsBad", cv);
    // Four misaligned commas drop lock
    sendWord(C);
    sendBit(1'b0); sendWord(C);
    sendBit(1'b0); sendWord(C);
    sendBit(1'b0);
    chk("lockAfter3Again", RxLocked, 1);
    sendWord(C);
    chk("lockAtDecidingBit", RxLocked, 1);
    sendBit(1'b0);
    chk("lockLost", RxLocked, 0);
    strobeCnt = 0;
    repeat (30) sendBit(1'b0);
    chk("noStrobesAfterLoss", strobeCnt, 0);

    // Opposite-disparity comma stream
    doReset(2);
    strobeCnt = 0;
    repeat (6) sendWord(NC);
    sendBit(1'b0);
    chk("rdpLocked", RxLocked, BOTH);
    chk("rdpStrobes", strobeCnt > 0, BOTH);

    // Reset in the middle of verification
    doReset(2);
    sendWord(C);
    sendWord(C);
    Reset = 1'b1;
    sendBit(1'b0);
    Reset = 1'b0;
    chk("midVerifyReset", {RxParallel, RxValid, RxComma, RxLocked}, 0);
    cv = '{C, C, 1'b1, 1'b0};
    sendWordChk(C, 1'b0, cv, "fresh0");
    sendWordChk(C, 1'b1, cv, "fresh1");
    sendWordChk(C, 1'b1, cv, "fresh2");
    sendWordChk(C, 1'b1, cv, "fresh3");
    sendBit(1'b0);
    cv = '{C, C, 1'b1, 1'b1};
    checkVec("fresh4Locks", cv);

    // Randomized traffic, checked every cycle by the model
    for (int it = 0; it < 300; it++) begin
      a = int'($urandom_range(0, 19));
      if (a == 0) doReset(1);
      else if (a < 9) sendWord(C);
      else if (a < 11) sendWord(NC);
      else if (a < 15) begin
        rw = W'($urandom_range(0, (1 << W) - 1));
        sendWord(rw);
      end else begin
        repeat ($urandom_range(1, 3)) sendBit(1'($urandom_range(0, 1)));
      end
    end

    @(negedge BitCLK);
    @(negedge BitCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
